// File: rtl/wims_serial_pkg.sv
// Shared definitions for the nibble-serial link receiver: rx FSM states,
// line levels, legal word-width range and the bit-counter width helper.
package wims_serial_pkg;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_DATA,
      RX_PARITY,
      RX_STOP,
      RX_WAIT_HIGH
   } rx_state_e;

   localparam logic START_BIT  = 1'b0;
   localparam logic STOP_BIT   = 1'b1;
   localparam logic IDLE_LEVEL = 1'b1;

   localparam int WIDTH_MIN = 4;
   localparam int WIDTH_MAX = 16;

   // Counter only has to reach WIDTH-1, so clog2(WIDTH) bits suffice.
   function automatic int rx_cnt_width(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/rx_shift_reg.sv
// WIDTH-bit serial-in shift-right register (74194 shift-right path):
// new bits enter at the MSB, so after WIDTH shifts the first bit is the LSB.
module rx_shift_reg #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             clear_n,
   input  logic             shift_en,
   input  logic             sync_clr,
   input  logic             ser_in,
   output logic [WIDTH-1:0] data
);

   // Shift register with synchronous clear taking priority over the shift.
   always_ff @(posedge clk or negedge clear_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values, regardless of statement order.
      if (!clear_n) begin
         data <= '0;
      end else if (sync_clr) begin
         data <= '0;
      end else if (shift_en) begin
         data <= {ser_in, data[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/serial_word_rx.sv
// Framed serial word receiver with a one-entry valid/ready holding buffer.
// Frame: start bit, WIDTH data bits LSB first, optional even parity, stop bit.
// Define WIMS_RX_PARITY_EN to add the parity bit, PARITY state and parity_err.
module serial_word_rx
   import wims_serial_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             clear_n,
   input  logic             sin,
   input  logic             sin_en,
   output logic [WIDTH-1:0] q,
   output logic             q_valid,
   input  logic             q_ready,
   output logic             frame_err,
   output logic             parity_err,
   output logic             overrun
);

   localparam int               CNT_W    = rx_cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
`ifdef WIMS_RX_PARITY_EN
   localparam rx_state_e        AFTER_DATA = RX_PARITY;
`else
   localparam rx_state_e        AFTER_DATA = RX_STOP;
`endif

   rx_state_e        state, state_nxt;
   logic [CNT_W-1:0] bit_cnt;
   logic [WIDTH-1:0] shift_q;
   logic             shift_en, shift_clr, cnt_clr;
   logic             stop_good, frame_bad, good_frame;
   logic             load;

   rx_shift_reg #(.WIDTH(WIDTH)) u_shift (
      .clk      (clk),
      .clear_n  (clear_n),
      .shift_en (shift_en),
      .sync_clr (shift_clr),
      .ser_in   (sin),
      .data     (shift_q)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) state <= RX_IDLE;
      else          state <= state_nxt;
   end

   // Next-state and datapath controls; nothing moves without a strobe.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // one unassigned, which would otherwise infer a latch.
      state_nxt = state;
      shift_en  = 1'b0;
      shift_clr = 1'b0;
      cnt_clr   = 1'b0;
      stop_good = 1'b0;
      frame_bad = 1'b0;
      if (sin_en) begin
         case (state)
            RX_IDLE: begin
               if (sin == START_BIT) begin
                  state_nxt = RX_DATA;
                  shift_clr = 1'b1;
                  cnt_clr   = 1'b1;
               end
            end
            RX_DATA: begin
               shift_en = 1'b1;
               if (bit_cnt == LAST_BIT) state_nxt = AFTER_DATA;
            end
`ifdef WIMS_RX_PARITY_EN
            RX_PARITY: state_nxt = RX_STOP;
`endif
            RX_STOP: begin
               if (sin == STOP_BIT) begin
                  stop_good = 1'b1;
                  state_nxt = RX_IDLE;
               end else begin
                  frame_bad = 1'b1;
                  state_nxt = RX_WAIT_HIGH;
               end
            end
            RX_WAIT_HIGH: begin
               // A low line here is the tail of a broken frame, not a start bit.
               if (sin == IDLE_LEVEL) state_nxt = RX_IDLE;
            end
            default: state_nxt = RX_IDLE;
         endcase
      end
   end

   // Data bit counter: cleared on the start bit, advanced on each data strobe.
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n)      bit_cnt <= '0;
      else if (cnt_clr)  bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + 1'b1;
   end

`ifdef WIMS_RX_PARITY_EN
   logic par_bad;

   // Even parity: data bits XOR parity bit must be 0; judged at the stop bit.
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n)                           par_bad <= 1'b0;
      else if (sin_en && state == RX_PARITY)  par_bad <= (^shift_q) ^ sin;
   end

   assign good_frame = stop_good & ~par_bad;

   // Parity error pulse, registered one cycle after the stop strobe.
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) parity_err <= 1'b0;
      else          parity_err <= stop_good & par_bad;
   end
`else
   assign good_frame = stop_good;
   assign parity_err = 1'b0;
`endif

   // A good word loads when the buffer is empty or drains on the same edge.
   assign load = good_frame & (~q_valid | q_ready);

   // Holding buffer and registered fault pulses.
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         q         <= '0;
         q_valid   <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (load) q <= shift_q;
         q_valid   <= load | (q_valid & ~q_ready);
         frame_err <= frame_bad;
         overrun   <= good_frame & q_valid & ~q_ready;
      end
   end

endmodule

// File: tb/tb_serial_word_rx.sv
// Scoreboard bench for serial_word_rx (WIDTH=4): stimulus pushes expected
// words into a queue, a monitor pops and compares on each buffer transfer
// and counts fault pulses; the stimulus checks pulse counts per scenario.
module tb_serial_word_rx;

   localparam int WIDTH = 4;

   logic             clk = 1'b0;
   logic             clear_n;
   logic             sin;
   logic             sin_en;
   logic [WIDTH-1:0] q;
   logic             q_valid;
   logic             q_ready;
   logic             frame_err;
   logic             parity_err;
   logic             overrun;

   int n_checks = 0;
   int n_pass   = 0;
   int n_ferr   = 0;
   int n_perr   = 0;
   int n_ovr    = 0;
   int b_ferr, b_perr, b_ovr;

   logic [WIDTH-1:0] exp_q[$];

   serial_word_rx #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .clear_n    (clear_n),
      .sin        (sin),
      .sin_en     (sin_en),
      .q          (q),
      .q_valid    (q_valid),
      .q_ready    (q_ready),
      .frame_err  (frame_err),
      .parity_err (parity_err),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Monitor: count fault pulses and score every word handed to the consumer.
   always @(negedge clk) begin
      if (clear_n) begin
         if (frame_err)  n_ferr++;
         if (parity_err) n_perr++;
         if (overrun)    n_ovr++;
         if (q_valid && q_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_word: got %0h, expected none", q);
            end else begin
               check("word", q, exp_q.pop_front());
            end
         end
      end
   end

   // One clock: drive line/strobe, pass the rising edge, settle 1 time unit.
   task automatic tick(input logic s, input logic en);
      sin    = s;
      sin_en = en;
      @(posedge clk);
      #1;
   endtask

   // One strobed bit, optionally followed by two unstrobed cycles of line noise.
   task automatic strobe_bit(input logic b, input logic gap);
      tick(b, 1'b1);
      if (gap) begin
         tick(~b, 1'b0);
         tick(b, 1'b0);
      end
   endtask

   // Start bit, data LSB first, and (with parity) the even-parity bit.
   task automatic send_data(input logic [WIDTH-1:0] word, input logic gap, input logic bad_par);
      strobe_bit(1'b0, gap);
      for (int i = 0; i < WIDTH; i++) strobe_bit(word[i], gap);
`ifdef WIMS_RX_PARITY_EN
      strobe_bit((^word) ^ bad_par, gap);
`endif
   endtask

   task automatic drain(input string name);
      q_ready = 1'b1;
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick(1'b1, 1'b0);
      check(name, exp_q.size(), 0);
      q_ready = 1'b0;
      tick(1'b1, 1'b0);
   endtask

   task automatic snap();
      b_ferr = n_ferr;
      b_perr = n_perr;
      b_ovr  = n_ovr;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      clear_n = 1'b0;
      sin     = 1'b1;
      sin_en  = 1'b0;
      q_ready = 1'b0;
      tick(1'b1, 1'b1);
      tick(1'b1, 1'b1);
      check("reset_q", q, 0);
      check("reset_q_valid", q_valid, 0);
      check("reset_frame_err", frame_err, 0);
      check("reset_parity_err", parity_err, 0);
      check("reset_overrun", overrun, 0);
      clear_n = 1'b1;
      tick(1'b1, 1'b1);

      // Reset mid-frame after two data bits, then a clean 4'b1111 frame.
      snap();
      tick(1'b0, 1'b1);
      tick(1'b1, 1'b1);
      tick(1'b0, 1'b1);
      clear_n = 1'b0;
      tick(1'b1, 1'b1);
      check("midreset_q_valid", q_valid, 0);
      clear_n = 1'b1;
      send_data(4'b1111, 1'b0, 1'b0);
      exp_q.push_back(4'b1111);
      tick(1'b1, 1'b1);
      drain("midreset_drain");
      check("midreset_frame_err", n_ferr - b_ferr, 0);
      check("midreset_parity_err", n_perr - b_perr, 0);
      check("midreset_overrun", n_ovr - b_ovr, 0);

      // Basic frame: visible right after the stop edge, cleared by one transfer.
      send_data(4'b1010, 1'b0, 1'b0);
      exp_q.push_back(4'b1010);
      tick(1'b1, 1'b1);
      check("basic_q_valid", q_valid, 1);
      check("basic_q", q, 4'b1010);
      q_ready = 1'b1;
      tick(1'b1, 1'b0);
      q_ready = 1'b0;
      check("basic_q_valid_cleared", q_valid, 0);
      check("basic_scoreboard", exp_q.size(), 0);

      // Gapped strobes with the line toggling between them.
      send_data(4'b1010, 1'b1, 1'b0);
      exp_q.push_back(4'b1010);
      strobe_bit(1'b1, 1'b1);
      drain("gapped_drain");

      // Back-to-back frames into a full buffer: second word dropped.
      snap();
      send_data(4'b1010, 1'b0, 1'b0);
      exp_q.push_back(4'b1010);
      tick(1'b1, 1'b1);
      send_data(4'b0101, 1'b0, 1'b0);
      tick(1'b1, 1'b1);
      check("overrun_q_held", q, 4'b1010);
      drain("overrun_drain");
      check("overrun_count", n_ovr - b_ovr, 1);

      // Same frames, but the buffer drains on the second stop edge.
      snap();
      send_data(4'b1010, 1'b0, 1'b0);
      exp_q.push_back(4'b1010);
      tick(1'b1, 1'b1);
      send_data(4'b0101, 1'b0, 1'b0);
      exp_q.push_back(4'b0101);
      q_ready = 1'b1;
      tick(1'b1, 1'b1);
      drain("sameedge_drain");
      check("sameedge_overrun", n_ovr - b_ovr, 0);

      // Framing error, low line held, then recovery and a good 4'b0011 frame.
      snap();
      send_data(4'b0011, 1'b0, 1'b0);
      tick(1'b0, 1'b1);
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
      check("framing_nothing_loaded", q_valid, 0);
      tick(1'b1, 1'b1);
      send_data(4'b0011, 1'b0, 1'b0);
      exp_q.push_back(4'b0011);
      tick(1'b1, 1'b1);
      drain("framing_drain");
      check("framing_frame_err", n_ferr - b_ferr, 1);
      check("framing_overrun", n_ovr - b_ovr, 0);

`ifdef WIMS_RX_PARITY_EN
      // Wrong parity drops the word; correct parity delivers it.
      snap();
      send_data(4'b0011, 1'b0, 1'b1);
      tick(1'b1, 1'b1);
      tick(1'b1, 1'b0);
      check("parity_bad_q_valid", q_valid, 0);
      check("parity_bad_pulse", n_perr - b_perr, 1);
      send_data(4'b0011, 1'b0, 1'b0);
      exp_q.push_back(4'b0011);
      tick(1'b1, 1'b1);
      drain("parity_good_drain");
      check("parity_good_no_pulse", n_perr - b_perr, 1);
      check("parity_frame_err", n_ferr - b_ferr, 0);
`else
      check("parity_err_never", n_perr, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/serial_word_rx.md
# serial_word_rx

Receiving end of the nibble-serial link driven by the 74194-style shift-right transmitter. Samples a framed bit stream (start bit, WIDTH data bits LSB first, optional parity, stop bit) on qualified clock cycles, reassembles the parallel word, and presents it through a one-entry valid/ready holding buffer. It sits between the serial line and the CPU-side register file or bus interface, and flags framing, parity and overrun faults.

## Interface
- WIDTH, default 4: data bits per frame; legal range 4..16.
- clk  input  1  system clock; all state updates on the rising edge.
- clear_n  input  1  reset; asynchronous, active-low.
- sin  input  1  serial line; idles high.
- sin_en  input  1  bit strobe; sin is sampled only on edges where sin_en=1.
- q  output  WIDTH  received word, held while q_valid=1.
- q_valid  output  1  holding buffer full.
- q_ready  input  1  consumer accepts; a transfer occurs on an edge with q_valid & q_ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled as 0.
- parity_err  output  1  one-cycle pulse: parity mismatch; constant 0 without parity support.
- overrun  output  1  one-cycle pulse: completed word dropped because the buffer was full.

## Operation
- States: IDLE, DATA, PARITY (only with parity), STOP, WAIT_HIGH.
- IDLE: on a strobe with sin=0, go to DATA and clear the bit counter. sin=1 or no strobe: stay.
- DATA: each strobe shifts sin into the MSB of the internal register, moving the other bits toward the LSB (shift-right, LSB first). After WIDTH strobes, go to PARITY if enabled, else STOP.
- PARITY: one strobe samples the parity bit, then go to STOP.
- STOP, strobe with sin=1: the frame is good unless parity failed. Go to IDLE.
- STOP, strobe with sin=0: pulse frame_err, discard the word, go to WAIT_HIGH.
- WAIT_HIGH: leave for IDLE only on a strobe with sin=1. A 0-level line never counts as a start bit.
- Good frame with the buffer empty, or with a same-edge transfer (q_valid & q_ready): load q and set q_valid=1. No overrun.
- Good frame with the buffer full and no transfer: keep the old q, drop the new word, pulse overrun.
- A transfer with no load clears q_valid. q holds its last value.
- Parity failure: pulse parity_err, drop the word, no load, go to IDLE.
- Cycles without a strobe freeze the FSM, counter and shift register. q_ready is still honoured on those cycles.

## Timing
- Reset values: state=IDLE, counter=0, shift register=0, q=0, q_valid=0, frame_err=0, parity_err=0, overrun=0.
- Reset asserted mid-frame aborts the frame immediately, with no error pulse. The first start bit is accepted on the first strobe after clear_n rises.
- Latency: q and q_valid update on the edge that samples the stop bit. The word is visible in the following cycle.
- Error pulses are registered and high for exactly the one cycle after the sampling edge.
- Minimum frame length is WIDTH+2 strobes (WIDTH+3 with parity). Back-to-back frames are accepted: a start bit may come on the strobe right after the stop bit.
- q_valid does not depend combinationally on q_ready.

## Configuration
- WIMS_RX_PARITY_EN defined: the frame carries one even-parity bit after the data bits; the PARITY state and parity_err logic exist.
- WIMS_RX_PARITY_EN not defined: no parity bit, no PARITY state, and parity_err is tied to 0. The port stays in place so instantiations are identical.

## Structure
- Package wims_serial_pkg holds:
  - the rx state enum;
  - START_BIT=1'b0, STOP_BIT=1'b1 and IDLE_LEVEL=1'b1;
  - WIDTH_MIN=4 and WIDTH_MAX=16;
  - a function returning the counter width for a given WIDTH.
- Sub-module rx_shift_reg: WIDTH-bit serial-in shift-right register with shift enable and synchronous clear. It mirrors the 74194 shift-right path.

## Test plan
All scenarios use WIDTH=4 and sin_en=1 every cycle unless stated.
- Reset mid-frame: pulse clear_n low after 2 data bits. Then send 0,1,1,1,1,1 → q=4'b1111 only, no error pulses.
- Basic frame: sin = 0, 0,1,0,1, 1 → q=4'b1010, q_valid=1 one cycle after the stop strobe. With q_ready=1 the next cycle, q_valid drops to 0.
- Gapped strobes: same frame with sin_en high one cycle in three, and sin toggling on the off cycles → still q=4'b1010.
- Overrun and same-edge transfer:
  - q_ready=0; send 4'b1010, then 4'b0101 back-to-back → q stays 4'b1010 and overrun pulses once.
  - Repeat with q_ready=1 on the second stop edge → q=4'b0101, no overrun.
- Framing error: send 0,1,1,0,0, then 0 as the stop bit, then hold sin=0 for 3 strobes, then 1, then a valid frame for 4'b0011 → one frame_err pulse, nothing loaded while low, then q=4'b0011.
- Parity (WIMS_RX_PARITY_EN defined): send 0,1,1,0,0 with parity 1 and stop 1 → one parity_err pulse, q_valid stays 0. The same frame with parity 0 → q=4'b0011.
